// File: rtl/rgb_pwm_pkg.sv
// Shared types and helpers for the RGB PWM driver.
// Duty triples are packed {r, g, b} so they overlay the 24-bit duty bus directly.
package rgb_pwm_pkg;

    typedef logic [7:0] duty_t;

    typedef struct packed {
        duty_t r;
        duty_t g;
        duty_t b;
    } rgb_duty_t;

    localparam duty_t PHASE_MAX = 8'd255;

    // Square-law perceptual mapping; the +255 makes 255 map back to 255.
    function automatic duty_t gamma_map(input duty_t d);
        logic [15:0] sq;
        sq = 16'(d) * 16'(d) + 16'd255;
        return sq[15:8];
    endfunction

endpackage

// File: rtl/rgb_pwm_driver_channel.sv
// Single PWM comparator: lit while the shared phase is below this channel's duty.
// The output is registered, so it trails the phase counter by one clock.
module pwm_channel
    import rgb_pwm_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  enable,
    input  duty_t phase,
    input  duty_t duty,
    output logic  lit
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lit <= 1'b0;
        end else begin
            lit <= enable && (phase < duty);
        end
    end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel LED PWM with a one-entry duty staging register applied at period boundaries.
// Optional macro RGB_PWM_GAMMA_EN applies a square-law mapping to duties as they are captured.
module rgb_pwm_driver
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE   = 47,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_i,
    input  logic        duty_valid_i,
    input  logic [23:0] duty_i,
    output logic        duty_ready_o,
    output logic [2:0]  led_rgb_o,
    output logic        update_o
);

    localparam logic [15:0] PRESCALE_RELOAD = 16'(PRESCALE - 1);

    logic [15:0] prescaler;
    duty_t       phase;
    logic        tick;
    logic        boundary;
    logic        accept;
    logic        pending_full;
    logic        out_of_reset;
    rgb_duty_t   pending;
    rgb_duty_t   active_duty;
    rgb_duty_t   capture_val;
    logic [2:0]  lit;

    assign tick     = enable_i && (prescaler == '0);
    // A disabled block is permanently at a boundary so staged duties land at once.
    assign boundary = !enable_i || (tick && (phase == PHASE_MAX));

    assign duty_ready_o = out_of_reset && !pending_full;
    assign accept       = duty_valid_i && duty_ready_o;

    always_comb begin
        capture_val = rgb_duty_t'(duty_i);
`ifdef RGB_PWM_GAMMA_EN
        capture_val.r = gamma_map(duty_i[23:16]);
        capture_val.g = gamma_map(duty_i[15:8]);
        capture_val.b = gamma_map(duty_i[7:0]);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= PRESCALE_RELOAD;
            phase     <= '0;
        end else if (!enable_i) begin
            prescaler <= PRESCALE_RELOAD;
            phase     <= '0;
        end else if (tick) begin
            prescaler <= PRESCALE_RELOAD;
            phase     <= phase + 8'd1;
        end else begin
            prescaler <= prescaler - 16'd1;
        end
    end

    // Capture needs ready, which needs pending empty, so it never collides with an apply.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_of_reset <= 1'b0;
            pending_full <= 1'b0;
            pending      <= '0;
            active_duty  <= '0;
            update_o     <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            update_o     <= boundary && pending_full;
            if (boundary && pending_full) begin
                active_duty  <= pending;
                pending_full <= 1'b0;
            end else if (accept) begin
                pending      <= capture_val;
                pending_full <= 1'b1;
            end
        end
    end

    pwm_channel u_red (
        .clk    (clk),
        .reset  (reset),
        .enable (enable_i),
        .phase  (phase),
        .duty   (active_duty.r),
        .lit    (lit[2])
    );

    pwm_channel u_green (
        .clk    (clk),
        .reset  (reset),
        .enable (enable_i),
        .phase  (phase),
        .duty   (active_duty.g),
        .lit    (lit[1])
    );

    pwm_channel u_blue (
        .clk    (clk),
        .reset  (reset),
        .enable (enable_i),
        .phase  (phase),
        .duty   (active_duty.b),
        .lit    (lit[0])
    );

    assign led_rgb_o = lit ^ {3{ACTIVE_LOW}};

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver at PRESCALE=1, ACTIVE_LOW=1: directed scenarios plus a random soak,
// checked against a period-level model (window position, active duties, one-deep staging queue).
module tb_rgb_pwm_driver;

    localparam bit AL = 1'b1;

    logic        clk;
    logic        reset;
    logic        enable_i;
    logic        duty_valid_i;
    logic [23:0] duty_i;
    logic        duty_ready_o;
    logic [2:0]  led_rgb_o;
    logic        update_o;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    logic [23:0] pq[$];
    int unsigned act[3];
    int unsigned pos;
    bit          rdy_ok;
    bit          accepted;
    int unsigned low_cnt[3];

    rgb_pwm_driver #(
        .PRESCALE   (1),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable_i     (enable_i),
        .duty_valid_i (duty_valid_i),
        .duty_i       (duty_i),
        .duty_ready_o (duty_ready_o),
        .led_rgb_o    (led_rgb_o),
        .update_o     (update_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned expect_duty(input int unsigned d);
`ifdef RGB_PWM_GAMMA_EN
        return (d * d + 255) / 256;
`else
        return d;
`endif
    endfunction

    function automatic int unsigned chan(input logic [23:0] t, input int c);
        return 32'(t[8*c +: 8]);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare.
    task automatic cycle(input logic en, input logic vld, input logic [23:0] d);
        logic [2:0]  exp_led;
        logic        exp_upd;
        bit          bnd;
        logic [23:0] t;
        enable_i     = en;
        duty_valid_i = vld;
        duty_i       = d;
        accepted     = vld && rdy_ok && (pq.size() == 0);
        exp_led      = {3{AL}};
        if (en) begin
            for (int c = 0; c < 3; c++) exp_led[c] = AL ^ (pos < act[c]);
            bnd = (pos == 255);
            pos = (pos + 1) % 256;
        end else begin
            bnd = 1'b1;
            pos = 0;
        end
        exp_upd = bnd && (pq.size() != 0);
        if (exp_upd) begin
            t = pq.pop_front();
            for (int c = 0; c < 3; c++) act[c] = expect_duty(chan(t, c));
        end
        if (accepted) pq.push_back(d);
        rdy_ok = 1'b1;
        @(posedge clk);
        #1;
        check("led", 32'(led_rgb_o), 32'(exp_led));
        check("update", 32'(update_o), 32'(exp_upd));
        check("ready", 32'(duty_ready_o), 32'(pq.size() == 0));
        for (int c = 0; c < 3; c++) if (led_rgb_o[c] !== AL) low_cnt[c]++;
    endtask

    task automatic check_window(input string tag, input logic [23:0] t);
        check({tag, "_blue_low"},  low_cnt[0], expect_duty(chan(t, 0)));
        check({tag, "_green_low"}, low_cnt[1], expect_duty(chan(t, 1)));
        check({tag, "_red_low"},   low_cnt[2], expect_duty(chan(t, 2)));
    endtask

    initial begin
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] c3;
        logic        en_r;
        bit          got_b;

        reset        = 1'b1;
        enable_i     = 1'b0;
        duty_valid_i = 1'b0;
        duty_i       = '0;
        rdy_ok       = 1'b0;
        pos          = 0;
        act          = '{0, 0, 0};
        low_cnt      = '{0, 0, 0};

        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_led", 32'(led_rgb_o), 32'd7);
            check("rst_update", 32'(update_o), 32'd0);
            check("rst_ready", 32'(duty_ready_o), 32'd0);
        end
        reset = 1'b0;

        // Idle after reset: pads dark, ready from the first clock.
        repeat (20) cycle(1'b0, 1'b0, '0);

        // Fixed triple, then two full periods.
        cycle(1'b0, 1'b1, 24'h80_00_FF);
        cycle(1'b0, 1'b0, '0);
        low_cnt = '{0, 0, 0};
        repeat (256) cycle(1'b1, 1'b0, '0);
        check_window("p1", 24'h80_00_FF);
        low_cnt = '{0, 0, 0};
        repeat (256) cycle(1'b1, 1'b0, '0);
        check_window("p2", 24'h80_00_FF);

        // Back-to-back offers: second one waits for the boundary.
        a = 24'($urandom);
        b = 24'($urandom);
        cycle(1'b1, 1'b1, a);
        got_b = 1'b0;
        for (int i = 0; i < 600 && !got_b; i++) begin
            cycle(1'b1, 1'b1, b);
            got_b = accepted;
        end
        for (int i = 0; i < 300 && pos != 0; i++) cycle(1'b1, 1'b0, '0);
        low_cnt = '{0, 0, 0};
        repeat (256) cycle(1'b1, 1'b0, '0);
        check_window("b2b", b);

        // Capture on the boundary edge itself.
        c3 = 24'($urandom);
        for (int i = 0; i < 300 && pos != 255; i++) cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, c3);
        low_cnt = '{0, 0, 0};
        repeat (256) cycle(1'b1, 1'b0, '0);
        check_window("bnd_old", b);
        low_cnt = '{0, 0, 0};
        repeat (256) cycle(1'b1, 1'b0, '0);
        check_window("bnd_new", c3);

        // Random soak with enable toggling and sporadic offers.
        en_r = 1'b1;
        repeat (1500) begin
            if ($urandom_range(0, 149) == 0) en_r = !en_r;
            cycle(en_r, ($urandom_range(0, 39) == 0), 24'($urandom));
        end

        // Reset mid-period with a triple still staged.
        repeat (2) cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 24'hC8_C8_C8);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 24'($urandom));
        repeat (99) cycle(1'b1, 1'b0, '0);
        #2;
        reset = 1'b1;
        #1;
        check("async_led", 32'(led_rgb_o), 32'd7);
        check("async_update", 32'(update_o), 32'd0);
        check("async_ready", 32'(duty_ready_o), 32'd0);
        pq.delete();
        act    = '{0, 0, 0};
        pos    = 0;
        rdy_ok = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hold_led", 32'(led_rgb_o), 32'd7);
        check("rst_hold_ready", 32'(duty_ready_o), 32'd0);
        reset = 1'b0;
        low_cnt = '{0, 0, 0};
        repeat (256) cycle(1'b1, 1'b0, '0);
        check_window("post_rst", 24'h00_00_00);
        repeat (40) cycle(1'b1, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
